even_issue_stage: RTL and testbench

- Transmitter side of the Even_Pipe input interface: buffers decoded even-pipe instructions and drives one instruction (or a bubble) per cycle into Even_Pipe.
- Reads the register file and checks RAW/WAW hazards against a per-register scoreboard.
- Uses the WB_reg_write_* port for same-cycle bypass.
- Sits between the decode/dual-issue logic and Even_Pipe.

---
 rtl/even_pipe_pkg.sv | 62 ++++++
 rtl/even_issue_stage_scoreboard.sv | 48 ++++
 rtl/even_issue_stage.sv | 203 ++++++++++++++++++++
 tb/tb_even_issue_stage.sv | 415 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/even_pipe_pkg.sv
// Shared definitions for the even-pipe issue path.
//   - field widths for the even-pipe interface
//   - 143-bit packed stage layout:
//       result [0:127], reg_dst [128:134], reg_wr [135], unit_id [136:138], latency [139:142]
//   - issue buffer entry layout
//   - default bubble opcode ID and execution unit encodings
//   - operand bypass helper
package even_pipe_pkg;

  localparam int REG_ADDR_W = 7;
  localparam int NUM_REGS   = 128;
  localparam int DATA_W     = 128;
  localparam int INSTR_W    = 32;
  localparam int ID_W       = 7;
  localparam int UNIT_W     = 3;
  localparam int LAT_W      = 4;
  localparam int SB_CNT_W   = 4;
  localparam int STAGE_W    = DATA_W + REG_ADDR_W + 1 + UNIT_W + LAT_W;

  localparam logic [ID_W-1:0] NOP_ID_DEFAULT = 7'd0;

  localparam logic [UNIT_W-1:0] UNIT_FX1  = 3'b000;
  localparam logic [UNIT_W-1:0] UNIT_FX2  = 3'b001;
  localparam logic [UNIT_W-1:0] UNIT_BYTE = 3'b010;
  localparam logic [UNIT_W-1:0] UNIT_SP   = 3'b011;

  // First member lands at bit 0 of the big-endian numbered stage word.
  typedef struct packed {
    logic [0:DATA_W-1]     result;
    logic [0:REG_ADDR_W-1] reg_dst;
    logic                  reg_wr;
    logic [0:UNIT_W-1]     unit_id;
    logic [0:LAT_W-1]      latency;
  } even_stage_t;

  typedef struct packed {
    logic [0:INSTR_W-1]      full_instr;
    logic [ID_W-1:0]         instr_id;
    logic [REG_ADDR_W-1:0]   reg_dst;
    logic [UNIT_W-1:0]       unit_id;
    logic [LAT_W-1:0]        latency;
    logic                    reg_wr;
    logic [REG_ADDR_W-1:0]   ra_addr;
    logic [REG_ADDR_W-1:0]   rb_addr;
    logic [REG_ADDR_W-1:0]   rc_addr;
    logic                    use_ra;
    logic                    use_rb;
    logic                    use_rc;
  } issue_entry_t;

  // A write-back landing this cycle is newer than the register file copy.
  function automatic logic [DATA_W-1:0] bypass_operand(
    input logic                  wb_en,
    input logic [REG_ADDR_W-1:0] wb_addr,
    input logic [DATA_W-1:0]     wb_data,
    input logic [REG_ADDR_W-1:0] src_addr,
    input logic [DATA_W-1:0]     rf_data
  );
    return (wb_en && (wb_addr == src_addr)) ? wb_data : rf_data;
  endfunction

endpackage

// File: rtl/even_issue_stage_scoreboard.sv
// even_scoreboard: per-register write-back countdown for the even pipe.
// Ports:
//   clk, rst            clock, async active-low reset (all counters to 0)
//   set_en, set_addr    load WB_DELAY into the counter of set_addr
//   query_a..query_d    registers to look up
//   busy_a..busy_d      counter > 1 (a value of 1 is covered by the bypass)
module even_scoreboard
  import even_pipe_pkg::*;
#(
  parameter int WB_DELAY = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  set_en,
  input  logic [REG_ADDR_W-1:0] set_addr,
  input  logic [REG_ADDR_W-1:0] query_a,
  input  logic [REG_ADDR_W-1:0] query_b,
  input  logic [REG_ADDR_W-1:0] query_c,
  input  logic [REG_ADDR_W-1:0] query_d,
  output logic                  busy_a,
  output logic                  busy_b,
  output logic                  busy_c,
  output logic                  busy_d
);

  localparam logic [SB_CNT_W-1:0] CNT_LOAD = SB_CNT_W'(WB_DELAY);

  logic [SB_CNT_W-1:0] cnt [NUM_REGS];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (set_en && (set_addr == REG_ADDR_W'(i)))
          cnt[i] <= CNT_LOAD;
        else if (cnt[i] != '0)
          cnt[i] <= cnt[i] - 1'b1;
      end
    end
  end

  assign busy_a = cnt[query_a] > SB_CNT_W'(1);
  assign busy_b = cnt[query_b] > SB_CNT_W'(1);
  assign busy_c = cnt[query_c] > SB_CNT_W'(1);
  assign busy_d = cnt[query_d] > SB_CNT_W'(1);

endmodule

// File: rtl/even_issue_stage.sv
// even_issue_stage: buffers decoded even-pipe instructions, checks RAW/WAW
// hazards against the scoreboard, reads operands (with WB bypass) and drives
// one instruction or a bubble per cycle into Even_Pipe.
// Ports:
//   clk, rst                   clock, async active-low reset
//   dec_*                      decode side, valid/ready push into the buffer
//   flush                      drop buffered instructions, force a bubble
//   rf_addr_*, rf_data_*       register file read (address from buffer head)
//   WB_reg_write_*             Even_Pipe write-back, used for bypass
//   full_instr .. imme18       registered issue outputs to Even_Pipe
//   issue_valid                a real instruction was issued
//   stall                      head valid but blocked by a hazard
// Optional: define EVEN_ISSUE_STATS_EN to add saturating stat_issued/stat_stalls.
module even_issue_stage
  import even_pipe_pkg::*;
#(
  parameter int              FIFO_DEPTH = 4,
  parameter int              WB_DELAY   = 8,
  parameter logic [ID_W-1:0] NOP_ID     = NOP_ID_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  dec_valid,
  output logic                  dec_ready,
  input  logic [0:INSTR_W-1]    dec_full_instr,
  input  logic [ID_W-1:0]       dec_instr_id,
  input  logic [REG_ADDR_W-1:0] dec_reg_dst,
  input  logic [UNIT_W-1:0]     dec_unit_id,
  input  logic [LAT_W-1:0]      dec_latency,
  input  logic                  dec_reg_wr,
  input  logic [REG_ADDR_W-1:0] dec_ra_addr,
  input  logic [REG_ADDR_W-1:0] dec_rb_addr,
  input  logic [REG_ADDR_W-1:0] dec_rc_addr,
  input  logic                  dec_use_ra,
  input  logic                  dec_use_rb,
  input  logic                  dec_use_rc,
  input  logic                  flush,
  output logic [REG_ADDR_W-1:0] rf_addr_a,
  output logic [REG_ADDR_W-1:0] rf_addr_b,
  output logic [REG_ADDR_W-1:0] rf_addr_c,
  input  logic [DATA_W-1:0]     rf_data_a,
  input  logic [DATA_W-1:0]     rf_data_b,
  input  logic [DATA_W-1:0]     rf_data_c,
  input  logic [REG_ADDR_W-1:0] WB_reg_write_addr,
  input  logic [DATA_W-1:0]     WB_reg_write_data,
  input  logic                  WB_reg_write_en,
  output logic [0:INSTR_W-1]    full_instr,
  output logic [ID_W-1:0]       instr_id,
  output logic [REG_ADDR_W-1:0] reg_dst,
  output logic [UNIT_W-1:0]     unit_id,
  output logic [LAT_W-1:0]      latency,
  output logic                  reg_wr,
  output logic [DATA_W-1:0]     ra_data,
  output logic [DATA_W-1:0]     rb_data,
  output logic [DATA_W-1:0]     rc_data,
  output logic [7:0]            imme7,
  output logic [9:0]            imme10,
  output logic [15:0]           imme16,
  output logic [17:0]           imme18,
  output logic                  issue_valid,
  output logic                  stall
`ifdef EVEN_ISSUE_STATS_EN
  ,
  output logic [31:0]           stat_issued,
  output logic [31:0]           stat_stalls
`endif
);

  localparam int ADDR_W = $clog2(FIFO_DEPTH);
  localparam int PTR_W  = ADDR_W + 1;

  issue_entry_t     fifo_mem [FIFO_DEPTH];
  issue_entry_t     head;
  issue_entry_t     dec_entry;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             fifo_empty, fifo_full;
  logic             head_valid, hazard, do_issue, do_push;
  logic             busy_a, busy_b, busy_c, busy_d;

  // Extra pointer bit tells full from empty once the pointers wrap.
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[PTR_W-1] != rd_ptr[PTR_W-1]) &&
                      (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
  assign head       = fifo_mem[rd_ptr[ADDR_W-1:0]];
  assign head_valid = !fifo_empty;

  // Ready depends only on buffer occupancy, never on this cycle's issue.
  assign dec_ready = rst && !fifo_full;
  assign do_push   = dec_valid && dec_ready && !flush;

  assign hazard   = (head.use_ra && busy_a) || (head.use_rb && busy_b) ||
                    (head.use_rc && busy_c) || (head.reg_wr && busy_d);
  assign stall    = head_valid && hazard;
  assign do_issue = head_valid && !hazard && !flush;

  assign rf_addr_a = head.ra_addr;
  assign rf_addr_b = head.rb_addr;
  assign rf_addr_c = head.rc_addr;

  always_comb begin
    dec_entry            = '0;
    dec_entry.full_instr = dec_full_instr;
    dec_entry.instr_id   = dec_instr_id;
    dec_entry.reg_dst    = dec_reg_dst;
    dec_entry.unit_id    = dec_unit_id;
    dec_entry.latency    = dec_latency;
    dec_entry.reg_wr     = dec_reg_wr;
    dec_entry.ra_addr    = dec_ra_addr;
    dec_entry.rb_addr    = dec_rb_addr;
    dec_entry.rc_addr    = dec_rc_addr;
    dec_entry.use_ra     = dec_use_ra;
    dec_entry.use_rb     = dec_use_rb;
    dec_entry.use_rc     = dec_use_rc;
  end

  always_ff @(posedge clk) begin
    if (do_push) fifo_mem[wr_ptr[ADDR_W-1:0]] <= dec_entry;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      rd_ptr <= wr_ptr;
    end else begin
      if (do_push)  wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_issue) rd_ptr <= rd_ptr + PTR_W'(1);
    end
  end

  even_scoreboard #(.WB_DELAY(WB_DELAY)) u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .set_en   (do_issue && head.reg_wr),
    .set_addr (head.reg_dst),
    .query_a  (head.ra_addr),
    .query_b  (head.rb_addr),
    .query_c  (head.rc_addr),
    .query_d  (head.reg_dst),
    .busy_a   (busy_a),
    .busy_b   (busy_b),
    .busy_c   (busy_c),
    .busy_d   (busy_d)
  );

  // Bubbles clear only the control fields; operand and immediate outputs hold.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      issue_valid <= 1'b0;
      reg_wr      <= 1'b0;
      instr_id    <= NOP_ID;
      unit_id     <= '0;
      latency     <= '0;
      reg_dst     <= '0;
      full_instr  <= '0;
      ra_data     <= '0;
      rb_data     <= '0;
      rc_data     <= '0;
      imme7       <= '0;
      imme10      <= '0;
      imme16      <= '0;
      imme18      <= '0;
    end else if (do_issue) begin
      issue_valid <= 1'b1;
      reg_wr      <= head.reg_wr;
      instr_id    <= head.instr_id;
      unit_id     <= head.unit_id;
      latency     <= head.latency;
      reg_dst     <= head.reg_dst;
      full_instr  <= head.full_instr;
      ra_data     <= bypass_operand(WB_reg_write_en, WB_reg_write_addr, WB_reg_write_data,
                                    head.ra_addr, rf_data_a);
      rb_data     <= bypass_operand(WB_reg_write_en, WB_reg_write_addr, WB_reg_write_data,
                                    head.rb_addr, rf_data_b);
      rc_data     <= bypass_operand(WB_reg_write_en, WB_reg_write_addr, WB_reg_write_data,
                                    head.rc_addr, rf_data_c);
      imme7       <= {head.full_instr[11], head.full_instr[11:17]};
      imme10      <= head.full_instr[8:17];
      imme16      <= head.full_instr[9:24];
      imme18      <= head.full_instr[7:24];
    end else begin
      issue_valid <= 1'b0;
      reg_wr      <= 1'b0;
      instr_id    <= NOP_ID;
      unit_id     <= '0;
      latency     <= '0;
    end
  end

`ifdef EVEN_ISSUE_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_issued <= '0;
      stat_stalls <= '0;
    end else begin
      if (do_issue && (stat_issued != '1)) stat_issued <= stat_issued + 32'd1;
      if (stall && (stat_stalls != '1))    stat_stalls <= stat_stalls + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_even_issue_stage.sv
// Self-checking bench for even_issue_stage: directed scenarios followed by
// randomized traffic, all compared against a transaction-level model that
// tracks the buffer as a queue and register availability as absolute edge numbers.
module tb_even_issue_stage;
  import even_pipe_pkg::*;

  localparam int              FIFO_DEPTH = 4;
  localparam int              WB_DELAY   = 8;
  localparam logic [6:0]      NOP        = 7'd0;

  logic         clk, rst, dec_valid, dec_ready, dec_reg_wr, flush;
  logic         dec_use_ra, dec_use_rb, dec_use_rc;
  logic [0:31]  dec_full_instr, full_instr;
  logic [6:0]   dec_instr_id, dec_reg_dst, dec_ra_addr, dec_rb_addr, dec_rc_addr;
  logic [6:0]   rf_addr_a, rf_addr_b, rf_addr_c, WB_reg_write_addr, instr_id, reg_dst;
  logic [2:0]   dec_unit_id, unit_id;
  logic [3:0]   dec_latency, latency;
  logic [127:0] rf_data_a, rf_data_b, rf_data_c, WB_reg_write_data;
  logic [127:0] ra_data, rb_data, rc_data;
  logic         WB_reg_write_en, reg_wr, issue_valid, stall;
  logic [7:0]   imme7;
  logic [9:0]   imme10;
  logic [15:0]  imme16;
  logic [17:0]  imme18;
`ifdef EVEN_ISSUE_STATS_EN
  logic [31:0]  stat_issued, stat_stalls;
`endif

  logic [127:0] rf_mem [128];
  assign rf_data_a = rf_mem[rf_addr_a];
  assign rf_data_b = rf_mem[rf_addr_b];
  assign rf_data_c = rf_mem[rf_addr_c];

  even_issue_stage #(.FIFO_DEPTH(FIFO_DEPTH), .WB_DELAY(WB_DELAY), .NOP_ID(NOP)) dut (
    .clk(clk), .rst(rst), .dec_valid(dec_valid), .dec_ready(dec_ready),
    .dec_full_instr(dec_full_instr), .dec_instr_id(dec_instr_id), .dec_reg_dst(dec_reg_dst),
    .dec_unit_id(dec_unit_id), .dec_latency(dec_latency), .dec_reg_wr(dec_reg_wr),
    .dec_ra_addr(dec_ra_addr), .dec_rb_addr(dec_rb_addr), .dec_rc_addr(dec_rc_addr),
    .dec_use_ra(dec_use_ra), .dec_use_rb(dec_use_rb), .dec_use_rc(dec_use_rc),
    .flush(flush), .rf_addr_a(rf_addr_a), .rf_addr_b(rf_addr_b), .rf_addr_c(rf_addr_c),
    .rf_data_a(rf_data_a), .rf_data_b(rf_data_b), .rf_data_c(rf_data_c),
    .WB_reg_write_addr(WB_reg_write_addr), .WB_reg_write_data(WB_reg_write_data),
    .WB_reg_write_en(WB_reg_write_en), .full_instr(full_instr), .instr_id(instr_id),
    .reg_dst(reg_dst), .unit_id(unit_id), .latency(latency), .reg_wr(reg_wr),
    .ra_data(ra_data), .rb_data(rb_data), .rc_data(rc_data), .imme7(imme7),
    .imme10(imme10), .imme16(imme16), .imme18(imme18), .issue_valid(issue_valid),
    .stall(stall)
`ifdef EVEN_ISSUE_STATS_EN
    , .stat_issued(stat_issued), .stat_stalls(stat_stalls)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1);
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0] full;
    logic [6:0]  id, dst, ra, rb, rc;
    logic [2:0]  unit;
    logic [3:0]  lat;
    bit          wr, ua, ub, uc;
  } tb_instr_t;

  typedef struct {
    int unsigned at;
    logic [6:0]  addr;
  } wb_t;

  tb_instr_t   mq[$];
  wb_t         wbq[$];
  int unsigned free_edge [128];
  int unsigned edge_n = 1;
  int unsigned last_issue_edge = 0;
  int          stall_seen = 0;
  int unsigned model_issued = 0, model_stalls = 0;
  tb_instr_t   dec_cur;
  bit          force_wb = 0;
  logic [127:0] wb_force = '0;

  logic [31:0]  e_full;
  logic [6:0]   e_id, e_dst;
  logic [2:0]   e_unit;
  logic [3:0]   e_lat;
  logic         e_wr, e_valid;
  logic [127:0] e_ra, e_rb, e_rc;
  logic [7:0]   e_i7;
  logic [9:0]   e_i10;
  logic [15:0]  e_i16;
  logic [17:0]  e_i18;

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic bit busy(input logic [6:0] r);
    return free_edge[r] > edge_n;
  endfunction

  // Immediates: big-endian field [a:b] of the word is value bits (31-a)..(31-b).
  function automatic logic [7:0] x_imm7(input logic [31:0] f);
    logic [6:0] v;
    v = 7'((f >> 14) & 32'h7F);
    return 8'($signed(v));
  endfunction

  function automatic logic [127:0] src_val(input logic [6:0] a);
    if (WB_reg_write_en && WB_reg_write_addr == a) return WB_reg_write_data;
    return rf_mem[a];
  endfunction

  task automatic model_reset();
    mq.delete();
    wbq.delete();
    for (int i = 0; i < 128; i++) free_edge[i] = 0;
    e_full = '0; e_id = NOP; e_dst = '0; e_unit = '0; e_lat = '0; e_wr = 1'b0;
    e_valid = 1'b0; e_ra = '0; e_rb = '0; e_rc = '0;
    e_i7 = '0; e_i10 = '0; e_i16 = '0; e_i18 = '0;
    model_issued = 0;
    model_stalls = 0;
  endtask

  function automatic tb_instr_t mk(input logic [31:0] full, input logic [6:0] id,
                                   input logic [6:0] dst, input bit wr,
                                   input logic [6:0] ra, input bit ua);
    tb_instr_t t;
    t = '{default: '0};
    t.full = full; t.id = id; t.dst = dst; t.wr = wr; t.ra = ra; t.ua = ua;
    t.unit = 3'd1; t.lat = 4'd6;
    return t;
  endfunction

  function automatic tb_instr_t rand_instr(input int unsigned span);
    tb_instr_t t;
    t.full = $urandom;
    t.id   = 7'($urandom);
    t.unit = 3'($urandom);
    t.lat  = 4'($urandom);
    t.dst  = 7'($urandom_range(span - 1));
    t.ra   = 7'($urandom_range(span - 1));
    t.rb   = 7'($urandom_range(span - 1));
    t.rc   = 7'($urandom_range(span - 1));
    t.wr   = 1'($urandom);
    t.ua   = 1'($urandom);
    t.ub   = 1'($urandom);
    t.uc   = ($urandom_range(3) == 0);
    return t;
  endfunction

  task automatic set_dec(input tb_instr_t t);
    dec_cur        = t;
    dec_full_instr = t.full;
    dec_instr_id   = t.id;
    dec_reg_dst    = t.dst;
    dec_unit_id    = t.unit;
    dec_latency    = t.lat;
    dec_reg_wr     = t.wr;
    dec_ra_addr    = t.ra;
    dec_rb_addr    = t.rb;
    dec_rc_addr    = t.rc;
    dec_use_ra     = t.ua;
    dec_use_rb     = t.ub;
    dec_use_rc     = t.uc;
  endtask

  // Plays Even_Pipe: a write lands WB_DELAY edges after its issue edge.
  task automatic drive_wb();
    if (wbq.size() != 0 && wbq[0].at == edge_n) begin
      WB_reg_write_en   = 1'b1;
      WB_reg_write_addr = wbq[0].addr;
      WB_reg_write_data = force_wb ? wb_force : rand128();
    end else begin
      WB_reg_write_en   = 1'b0;
      WB_reg_write_addr = 7'($urandom);
      WB_reg_write_data = rand128();
    end
  endtask

  // One clock: check combinational outputs, clock, advance model, check registers.
  task automatic step();
    tb_instr_t    h;
    bit           hv, hz, iss, psh, rdy, fl;
    logic [127:0] da, db, dc;
    h = '{default: '0};
    da = '0; db = '0; dc = '0;
    #1;
    hv  = (mq.size() != 0);
    rdy = (mq.size() < FIFO_DEPTH);
    hz  = 1'b0;
    check("dec_ready", dec_ready, rdy);
    if (hv) begin
      h  = mq[0];
      hz = (h.ua && busy(h.ra)) || (h.ub && busy(h.rb)) ||
           (h.uc && busy(h.rc)) || (h.wr && busy(h.dst));
      check("rf_addr_a", rf_addr_a, h.ra);
      check("rf_addr_b", rf_addr_b, h.rb);
      check("rf_addr_c", rf_addr_c, h.rc);
    end
    check("stall", stall, hv && hz);
    if (stall) stall_seen++;
    fl  = flush;
    iss = hv && !hz && !fl;
    psh = dec_valid && rdy && !fl;
    if (iss) begin
      da = src_val(h.ra);
      db = src_val(h.rb);
      dc = src_val(h.rc);
    end
    if (hv && hz) model_stalls++;
    @(posedge clk);
    #1;
    if (fl) mq.delete();
    else begin
      if (iss) void'(mq.pop_front());
      if (psh) mq.push_back(dec_cur);
    end
    if (WB_reg_write_en) begin
      rf_mem[WB_reg_write_addr] = WB_reg_write_data;
      if (wbq.size() != 0 && wbq[0].at == edge_n) void'(wbq.pop_front());
    end
    if (iss) begin
      e_valid = 1'b1; e_id = h.id; e_dst = h.dst; e_unit = h.unit; e_lat = h.lat;
      e_wr = h.wr; e_full = h.full; e_ra = da; e_rb = db; e_rc = dc;
      e_i7  = x_imm7(h.full);
      e_i10 = 10'((h.full >> 14) & 32'h3FF);
      e_i16 = 16'((h.full >> 7) & 32'hFFFF);
      e_i18 = 18'((h.full >> 7) & 32'h3FFFF);
      model_issued++;
      if (h.wr) begin
        free_edge[h.dst] = edge_n + WB_DELAY;
        wbq.push_back('{edge_n + WB_DELAY, h.dst});
      end
    end else begin
      e_valid = 1'b0; e_wr = 1'b0; e_id = NOP; e_unit = '0; e_lat = '0;
    end
    if (issue_valid) last_issue_edge = edge_n;
    edge_n++;
    check("issue_valid", issue_valid, e_valid);
    check("instr_id", instr_id, e_id);
    check("reg_wr", reg_wr, e_wr);
    check("reg_dst", reg_dst, e_dst);
    check("unit_id", unit_id, e_unit);
    check("latency", latency, e_lat);
    check("full_instr", full_instr, e_full);
    check("ra_data", ra_data, e_ra);
    check("rb_data", rb_data, e_rb);
    check("rc_data", rc_data, e_rc);
    check("imme7", imme7, e_i7);
    check("imme10", imme10, e_i10);
    check("imme16", imme16, e_i16);
    check("imme18", imme18, e_i18);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      dec_valid = 1'b0;
      flush     = 1'b0;
      drive_wb();
      step();
    end
  endtask

  task automatic push(input tb_instr_t t);
    set_dec(t);
    dec_valid = 1'b1;
    flush     = 1'b0;
    drive_wb();
    step();
    dec_valid = 1'b0;
  endtask

  // Idle until the DUT issues, bounded; reports whether it did.
  task automatic wait_issue(input int budget, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      idle(1);
      if (issue_valid) seen = 1'b1;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int unsigned prod_edge;
    bit          seen;

    rst = 1'b0; dec_valid = 1'b0; flush = 1'b0;
    set_dec(mk(32'h0, 7'h0, 7'd0, 1'b0, 7'd0, 1'b0));
    WB_reg_write_en = 1'b0; WB_reg_write_addr = '0; WB_reg_write_data = '0;
    for (int i = 0; i < 128; i++) rf_mem[i] = rand128();
    model_reset();

    // reset / idle
    repeat (2) @(posedge clk);
    #1;
    check("rst_issue_valid", issue_valid, 1'b0);
    check("rst_instr_id", instr_id, NOP);
    check("rst_reg_wr", reg_wr, 1'b0);
    check("rst_dec_ready", dec_ready, 1'b0);
    #3 rst = 1'b1;
    idle(2);

    // single issue
    rf_mem[1] = {16{8'h11}};
    push(mk(32'h12345678, 7'h55, 7'd7, 1'b1, 7'd1, 1'b1));
    idle(1);
    check("single_valid", issue_valid, 1'b1);
    check("single_dst", reg_dst, 7'd7);
    check("single_ra", ra_data, {16{8'h11}});
    check("single_imme10", imme10, 10'h0D1);
    idle(10);

    // RAW stall with bypass on the consumer's issue edge
    force_wb = 1'b1;
    wb_force = {16{8'hAA}};
    push(mk(32'hA0000001, 7'h21, 7'd7, 1'b1, 7'd3, 1'b0));
    push(mk(32'hB0000002, 7'h22, 7'd9, 1'b0, 7'd7, 1'b1));
    check("raw_prod_valid", issue_valid, 1'b1);
    prod_edge  = last_issue_edge;
    stall_seen = 0;
    wait_issue(20, seen);
    check("raw_cons_seen", seen, 1'b1);
    check("raw_stall_cycles", stall_seen, 7);
    check("raw_gap", last_issue_edge - prod_edge, WB_DELAY);
    check("raw_bypass", ra_data, {16{8'hAA}});
    force_wb = 1'b0;
    idle(10);

    // FIFO full
    push(mk(32'h0C0FFEE0, 7'h30, 7'd20, 1'b1, 7'd0, 1'b0));
    for (int i = 0; i < 4; i++)
      push(mk(32'h11110000 + i, 7'h31, 7'd21, 1'b0, 7'd20, 1'b1));
    check("full_ready_low", dec_ready, 1'b0);
    push(mk(32'hDEAD0001, 7'h32, 7'd22, 1'b1, 7'd0, 1'b0));
    push(mk(32'hDEAD0002, 7'h33, 7'd23, 1'b1, 7'd0, 1'b0));
    wait_issue(20, seen);
    check("full_pop_seen", seen, 1'b1);
    check("full_ready_back", dec_ready, 1'b1);
    idle(12);

    // flush keeps the scoreboard
    push(mk(32'h5A5A0001, 7'h40, 7'd30, 1'b1, 7'd0, 1'b0));
    for (int i = 0; i < 3; i++)
      push(mk(32'h5A5A0010 + i, 7'h41, 7'd31, 1'b0, 7'd30, 1'b1));
    set_dec(mk(32'h5A5A00FF, 7'h42, 7'd50, 1'b1, 7'd0, 1'b0));
    dec_valid = 1'b1;
    flush     = 1'b1;
    drive_wb();
    step();
    flush     = 1'b0;
    dec_valid = 1'b0;
    check("flush_bubble", issue_valid, 1'b0);
    idle(1);
    check("flush_empty_stall", stall, 1'b0);
    push(mk(32'h5A5A0100, 7'h43, 7'd32, 1'b0, 7'd30, 1'b1));
    check("flush_sb_stall", stall, 1'b1);
    idle(12);

    // async reset in the middle of a stall
    push(mk(32'h77770001, 7'h50, 7'd40, 1'b1, 7'd0, 1'b0));
    push(mk(32'h77770002, 7'h51, 7'd41, 1'b0, 7'd40, 1'b1));
    idle(2);
    check("pre_rst_stall", stall, 1'b1);
    #3 rst = 1'b0;
    #1;
    check("arst_issue_valid", issue_valid, 1'b0);
    check("arst_instr_id", instr_id, NOP);
    check("arst_reg_dst", reg_dst, 7'd0);
    check("arst_full_instr", full_instr, 32'd0);
    check("arst_dec_ready", dec_ready, 1'b0);
    check("arst_stall", stall, 1'b0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    model_reset();
    push(mk(32'h77770003, 7'h52, 7'd42, 1'b0, 7'd40, 1'b1));
    check("post_rst_no_stall", stall, 1'b0);
    idle(1);
    check("post_rst_issue", issue_valid, 1'b1);
    idle(4);

    // randomized traffic over a small register window to provoke hazards
    for (int i = 0; i < 1500; i++) begin
      set_dec(rand_instr(8));
      dec_valid = ($urandom_range(99) < 70);
      flush     = ($urandom_range(99) < 3);
      drive_wb();
      step();
    end
    idle(20);

`ifdef EVEN_ISSUE_STATS_EN
    check("stat_issued", stat_issued, model_issued);
    check("stat_stalls", stat_stalls, model_stalls);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
